// File: rtl/instr_issue_sched.sv
// instr_issue_sched: instruction FIFO with a hazard-aware single-issue scheduler
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_instr/in_valid     host instruction push; in_ready high while count < DEPTH
//   issue_instr/valid     registered issue to the decoder; all-zero when not valid
//   issue_hold            decoder back-pressure, blocks pop/issue
//   flush                 synchronous clear of queued instructions
//   resume                pulse that leaves HALT; halted reports HALT state
//   array_busy            MAC latency counter nonzero
//   fifo_count            current occupancy
//   stall_cycles          saturating count of cycles spent in STALL
module instr_issue_sched #(
    parameter int DEPTH   = 8,
    parameter int MAC_LAT = 16,
    parameter int WT_LAT  = 4,
    parameter int CW      = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [63:0]            in_instr,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [63:0]            issue_instr,
    output logic                   issue_valid,
    input  logic                   issue_hold,
    input  logic                   flush,
    input  logic                   resume,
    output logic                   halted,
    output logic                   array_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            stall_cycles
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t        r_state;
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [CW-1:0] r_mac;
    logic [CW-1:0] r_wt;

    logic [63:0]   w_head;
    logic [4:0]    w_op;
    logic          w_mac_busy;
    logic          w_wt_busy;
    logic          w_haz;
    logic          w_push;
    logic          w_pop;
    logic          w_issuable;
    logic          w_ready;

    assign w_head = r_mem[r_rp];
    assign w_op   = w_head[63:59];

    // A waiting instruction may leave in the counter's last busy cycle, so it
    // reaches the decoder exactly when the counter reads zero.
    assign w_mac_busy = r_mac > CW'(1);
    assign w_wt_busy  = r_wt > CW'(1);

    assign w_haz = (w_op == 5'b00001 && w_wt_busy) ||
                   (w_op == 5'b00010 && (w_mac_busy || w_wt_busy)) ||
                   (w_op == 5'b00011 && w_mac_busy);

    assign w_ready    = r_cnt < (AW+1)'(DEPTH);
    assign w_push     = in_valid && w_ready && !flush;
    assign w_pop      = r_cnt != '0 && !issue_hold && !flush && r_state != HALT && !w_haz;
    // NOP and HALT are consumed from the queue but never reach the decoder.
    assign w_issuable = w_op != 5'b00000 && w_op != 5'b11111;

    assign in_ready   = w_ready;
    assign halted     = r_state == HALT;
    assign array_busy = r_mac != '0;
    assign fifo_count = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_mac        <= '0;
            r_wt         <= '0;
            issue_instr  <= '0;
            issue_valid  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop) r_rp <= r_rp + 1'b1;
                r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            // In-flight array work keeps counting down even across a flush.
            r_mac <= (w_pop && w_op == 5'b00001) ? CW'(MAC_LAT) :
                     (r_mac != '0) ? r_mac - 1'b1 : r_mac;
            r_wt  <= (w_pop && w_op == 5'b00010) ? CW'(WT_LAT) :
                     (r_wt != '0) ? r_wt - 1'b1 : r_wt;
            issue_instr <= (w_pop && w_issuable) ? w_head : '0;
            issue_valid <= w_pop && w_issuable;
            if (r_state == STALL && !issue_hold && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 1'b1;
            r_state <= (r_state == HALT) ? (resume ? RUN : HALT) :
                       flush ? RUN :
                       w_pop ? ((w_op == 5'b11111) ? HALT : RUN) :
                       (r_cnt != '0 && !issue_hold && w_haz) ? STALL : r_state;
        end
    end
endmodule

// File: tb/tb_instr_issue_sched.sv
// tb_instr_issue_sched: self-checking bench for instr_issue_sched
module tb_instr_issue_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] issue_instr;
    logic        issue_valid;
    logic        issue_hold = 1'b0;
    logic        flush = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
    logic        array_busy;
    logic [3:0]  fifo_count;
    logic [15:0] stall_cycles;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] q[$];

    typedef struct {
        logic [63:0] ins;
        logic        ev;
        logic        eh;
    } vec_t;
    vec_t tbl [10];

    instr_issue_sched dut (
        .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .issue_instr(issue_instr), .issue_valid(issue_valid),
        .issue_hold(issue_hold), .flush(flush), .resume(resume), .halted(halted),
        .array_busy(array_busy), .fifo_count(fifo_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [15:0] a, input logic [15:0] d);
        return {op, a, d, 11'h0, d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w, input logic exp_issue);
        if (exp_issue) q.push_back(w);
        in_instr = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard consumer: every issued word must match the oldest expected one.
    always @(negedge clk) begin
        if (issue_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got %h expected no issue", issue_instr);
            end else begin
                chk("issue_order", issue_instr, q.pop_front());
            end
        end else begin
            chk("nop_zero", issue_instr, 64'h0);
        end
    end

    initial begin
        logic [63:0] mac, st, sw, rw, w;
        logic [15:0] s0;
        logic        pat [6];

        mac = mk(5'b00001, 16'h0000, 16'h0001);
        st  = mk(5'b00011, 16'h0003, 16'h0000);
        sw  = mk(5'b00010, 16'h0020, 16'h1111);
        rw  = mk(5'b00101, 16'h0030, 16'h2222);

        tbl[0] = '{mk(5'b00100, 16'h0010, 16'hABCD), 1'b1, 1'b0};
        tbl[1] = '{mk(5'b00101, 16'h0011, 16'h1234), 1'b1, 1'b0};
        tbl[2] = '{mk(5'b00110, 16'h0012, 16'h5678), 1'b1, 1'b0};
        tbl[3] = '{mk(5'b01010, 16'h0013, 16'h9ABC), 1'b1, 1'b0};
        tbl[4] = '{mk(5'b10101, 16'h0014, 16'hDEF0), 1'b1, 1'b0};
        tbl[5] = '{mk(5'b00000, 16'h0015, 16'h0F0F), 1'b0, 1'b0};
        tbl[6] = '{mk(5'b11111, 16'h0016, 16'hF0F0), 1'b0, 1'b1};
        tbl[7] = '{mk(5'b00001, 16'h0017, 16'h1357), 1'b1, 1'b0};
        tbl[8] = '{mk(5'b00010, 16'h0018, 16'h2468), 1'b1, 1'b0};
        tbl[9] = '{mk(5'b00011, 16'h0019, 16'hAAAA), 1'b1, 1'b0};

        #2;
        chk("rst_valid", issue_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", array_busy, 0);
        step();
        rst_n = 1'b1;
        step();

        // single-instruction vectors: push at edge N, outcome visible after N+1
        for (int i = 0; i < 10; i++) begin
            push(tbl[i].ins, tbl[i].ev);
            chk("vec_count_push", fifo_count, 1);
            step();
            chk("vec_valid", issue_valid, tbl[i].ev);
            chk("vec_instr", issue_instr, tbl[i].ev ? tbl[i].ins : 64'h0);
            chk("vec_halted", halted, tbl[i].eh);
            chk("vec_count", fifo_count, 0);
            if (tbl[i].eh) begin
                repeat (2) step();
                chk("vec_halt_hold", halted, 1);
                resume = 1'b1;
                step();
                resume = 1'b0;
                chk("vec_resume", halted, 0);
            end
            repeat (20) step();
        end

        // MAC then STORE: STORE leaves MAC_LAT edges after the MAC
        push(mac, 1'b1);
        push(st, 1'b1);
        chk("ms_mac_valid", issue_valid, 1);
        chk("ms_busy0", array_busy, 1);
        s0 = stall_cycles;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("ms_valid", issue_valid, k == 16);
            chk("ms_busy", array_busy, k < 16);
        end
        chk("ms_stall", stall_cycles - s0, 15);
        repeat (20) step();

        // SEND WEIGHTS, two receives, MAC, receive: MAC waits for WT_LAT
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        issue_hold = 1'b1;
        push(sw, 1'b1);
        push(rw, 1'b1);
        push(rw ^ 64'h1, 1'b1);
        push(mac, 1'b1);
        push(rw ^ 64'h2, 1'b1);
        chk("sw_held", issue_valid, 0);
        chk("sw_held_count", fifo_count, 5);
        s0 = stall_cycles;
        issue_hold = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("sw_pattern", issue_valid, pat[k]);
        end
        chk("sw_stall", stall_cycles - s0, 1);
        repeat (20) step();

        // full FIFO, rejected pushes, in-order drain; three rounds to wrap pointers
        for (int r = 0; r < 3; r++) begin
            issue_hold = 1'b1;
            for (int i = 0; i < 8; i++) begin
                chk("full_ready", in_ready, 1);
                push(mk(5'b00100, 16'(r * 8 + i), 16'(16'hC000 + r * 8 + i)), 1'b1);
            end
            chk("full_count", fifo_count, 8);
            chk("full_not_ready", in_ready, 0);
            push(mk(5'b00110, 16'hDEAD, 16'hBEEF), 1'b0);
            chk("full_reject", fifo_count, 8);
            issue_hold = 1'b0;
            in_instr = mk(5'b00110, 16'hFACE, 16'hFEED);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("full_pop_no_push", fifo_count, 7);
            chk("drain_valid", issue_valid, 1);
            for (int i = 1; i < 8; i++) begin
                step();
                chk("drain_valid", issue_valid, 1);
            end
            step();
            chk("drain_end", issue_valid, 0);
            chk("drain_count", fifo_count, 0);
        end

        // sustained one-per-cycle stream with simultaneous push and pop
        for (int i = 0; i < 6; i++) begin
            push(mk(5'b00110, 16'(16'h0100 + i), 16'(16'h7000 + i)), 1'b1);
            chk("stream_valid", issue_valid, i > 0);
            chk("stream_count", fifo_count, 1);
        end
        step();
        chk("stream_last", issue_valid, 1);
        chk("stream_empty", fifo_count, 0);
        repeat (20) step();

        // HALT and NOP handling
        issue_hold = 1'b1;
        push(mac, 1'b1);
        push(mk(5'b11111, 16'h0, 16'h0), 1'b0);
        push(mk(5'b00100, 16'h0040, 16'h4444), 1'b1);
        push(mk(5'b00000, 16'h0041, 16'h5555), 1'b0);
        push(mk(5'b00110, 16'h0042, 16'h6666), 1'b1);
        issue_hold = 1'b0;
        step();
        chk("halt_mac", issue_valid, 1);
        chk("halt_not_yet", halted, 0);
        step();
        chk("halt_enter", halted, 1);
        chk("halt_valid", issue_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("halt_stay", halted, 1);
            chk("halt_no_issue", issue_valid, 0);
            chk("halt_count", fifo_count, 3);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_halted", halted, 0);
        chk("resume_valid", issue_valid, 0);
        step();
        chk("after_resume", issue_valid, 1);
        step();
        chk("nop_slot", issue_valid, 0);
        chk("nop_count", fifo_count, 1);
        step();
        chk("after_nop", issue_valid, 1);
        chk("halt_seq_empty", fifo_count, 0);
        repeat (20) step();

        // flush during STALL: STORE dropped, array counter keeps running
        push(mac, 1'b1);
        push(st, 1'b0);
        repeat (5) step();
        flush = 1'b1;
        in_instr = mk(5'b00100, 16'hBAD0, 16'hBAD1);
        in_valid = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", fifo_count, 0);
        chk("flush_valid", issue_valid, 0);
        chk("flush_busy", array_busy, 1);
        s0 = stall_cycles;
        for (int k = 7; k <= 16; k++) begin
            step();
            chk("flush_busy_run", array_busy, k < 16);
        end
        chk("flush_stall_frozen", stall_cycles, s0);
        w = mk(5'b00100, 16'h0050, 16'h5050);
        push(w, 1'b1);
        step();
        chk("post_flush_issue", issue_valid, 1);
        repeat (20) step();

        // asynchronous reset in the middle of a stall with queued work
        push(mac, 1'b1);
        push(st, 1'b0);
        push(mk(5'b00100, 16'h0060, 16'h6060), 1'b0);
        repeat (2) step();
        chk("pre_rst_count", fifo_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", issue_valid, 0);
        chk("arst_instr", issue_instr, 64'h0);
        chk("arst_count", fifo_count, 0);
        chk("arst_busy", array_busy, 0);
        chk("arst_stall", stall_cycles, 0);
        chk("arst_halted", halted, 0);
        chk("arst_ready", in_ready, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (20) step();
        chk("post_rst_count", fifo_count, 0);

        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
